seq_det_ctrl: RTL
=================

Name: seq_det_ctrl

Overview:
Configurable serial pattern-detection controller for the FSM sequence-detector family.
- Accepts a pattern configuration through a valid/ready handshake, arms a programmable matcher on a serial bit stream, and counts matches.
- Optionally stops after a target number of matches and reports done.
- Sits between the control/CSR side and any serial input needing 1010-style detection; replaces per-pattern hard-coded detectors.

Parameters:
MAX_LEN  8  maximum pattern length in bits (2..16)
CNT_W  8  width of match counter and target

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration offered
cfg_ready  out  1  configuration can be accepted
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first received bit, bit [0] the last
cfg_len  in  $clog2(MAX_LEN+1)  pattern length, legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after a match
cfg_target  in  CNT_W  stop after this many matches; 0 = run continuously
cfg_err  out  1  one-cycle pulse: illegal cfg_len rejected
start  in  1  arm the matcher (level sampled each clk)
abort  in  1  return to IDLE
x  in  1  serial data bit
x_valid  in  1  x is a valid sample this cycle
match  out  1  one-cycle pulse per detected pattern
match_cnt  out  CNT_W  matches since last start, saturating
busy  out  1  high in ARMED
done  out  1  high in DONE

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values:
  - State IDLE; match=0, match_cnt=0, busy=0, done=0, cfg_err=0.
  - Default config: pattern=…1010 (low 4 bits), len=4, overlap=1, target=0.
  - History and fill count cleared.
- States:
  - IDLE: start -> ARMED.
  - ARMED: target reached -> DONE; abort -> IDLE.
  - DONE: start -> ARMED; abort -> IDLE.
- Priority within a cycle is abort > start > cfg.
- cfg_ready = (state==IDLE || state==DONE) && !start && !abort.
- A cfg handshake (cfg_valid && cfg_ready) latches all cfg_* fields at that edge.
  - If cfg_len==0 or cfg_len>MAX_LEN, the config is NOT latched; cfg_err pulses the next cycle.
- Start from IDLE or DONE:
  - Clears history, fill count, match_cnt and done; enters ARMED next cycle.
  - start while ARMED is ignored.
- ARMED sample handling: on each edge with x_valid=1:
  - History shifts left with x entering at bit 0.
  - fill = min(fill+1, MAX_LEN).
  - x_valid=0 leaves history unchanged; gaps are allowed.
- Match condition, evaluated on the post-shift history: fill>=len && hist[len-1:0]==pattern[len-1:0].
  - match is registered: high for exactly the one cycle following the completing sample's edge.
- On a match:
  - match_cnt increments, saturating at 2^CNT_W-1.
  - If overlap=0, fill resets to 0 at that same edge, so the next match needs len fresh samples.
- Target stop: if target!=0 and the incremented count equals target, the state goes to DONE at the same edge as the match.
  - done rises together with that match pulse; further x ignored.
- abort:
  - Clears history and fill; match_cnt retained; busy/done drop next cycle.
  - A pending match from the abort cycle's sample is suppressed.
- Samples arriving in IDLE/DONE are ignored.
- Asserting rst_n low mid-operation returns everything to reset values immediately.

Decomposition:
- Package seq_det_pkg: state enum (IDLE, ARMED, DONE), default pattern/len constants, length-width function.
- One sub-module, seq_match_core: shift register, fill counter, masked compare, overlap clear; outputs a raw hit.
- Handshake, FSM and counter stay in seq_det_ctrl.

Test Plan:
- Reset defaults, start, stream 1,0,1,0,1,0,1,0 with x_valid=1, overlap=1 -> match pulses after bits 4, 6, 8; match_cnt=3.
- cfg pattern=1010, len=4, overlap=0, then the same stream -> matches after bits 4 and 8 only; match_cnt=2.
- cfg pattern=11, len=2, target=2, stream 1,1,1,1 -> match after bits 2 and 3; done=1 with the second match; bit 4 ignored; match_cnt=2.
- Stream 1,0,1,0 with x_valid low for 3 cycles between bits 2 and 3 -> single match after bit 4; no match during gaps.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err pulses each time; next run still detects the previously latched pattern.
- ARMED, send 1,0,1; abort together with bit 0 -> no match; IDLE next cycle; cfg_ready=1; start+cfg same cycle -> cfg_ready=0 and config unchanged.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern-detection controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Power-up configuration: detect 1010 with overlap, run continuously.
    localparam int          DEF_LEN     = 4;
    localparam logic [15:0] DEF_PATTERN = 16'b1010;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Configuration channel of seq_det_ctrl.
// Handshake: a config transfers on a rising clk edge where cfg_valid && cfg_ready;
// cfg_valid must not depend on cfg_ready, and the cfg_* fields are sampled only at that edge.
interface seq_det_ctrl_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    import seq_det_pkg::*;

    localparam int LEN_W = len_width(MAX_LEN);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/seq_match_core.sv
// Serial matcher: history shift register, fill counter and length-masked compare.
// hit_o is combinational on the post-shift history of the current sample.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_i,
    input  logic               sample_i,
    input  logic               x_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               overlap_i,
    output logic               hit_o
);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q, fill_d;

    assign hist_d = {hist_q[MAX_LEN-2:0], x_i};
    assign fill_d = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end
    end

    // The fill requirement keeps stale or cleared history from producing a hit.
    assign hit_o = sample_i && (fill_d >= len_i) &&
                   ((hist_d & mask) == (pattern_i & mask));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear_i) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (sample_i) begin
            hist_q <= hist_d;
            fill_q <= (hit_o && !overlap_i) ? '0 : fill_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern-detection controller: config handshake, run FSM
// (IDLE/ARMED/DONE), saturating match counter and optional stop-at-target.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_det_ctrl_if.slave    cfg,
    input  logic             start,
    input  logic             abort,
    input  logic             x,
    input  logic             x_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done,
    output state_e           dbg_state_o
);

    localparam int LEN_W = len_width(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic [CNT_W-1:0]   tgt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               match_q;
    logic               err_q;

    logic             cfg_fire;
    logic             len_ok;
    logic             start_go;
    logic             sample_en;
    logic             clear;
    logic             hit;
    logic [CNT_W-1:0] cnt_inc;

    // abort outranks start, and both outrank a config offer.
    assign cfg.cfg_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !start && !abort;
    assign cfg_fire      = cfg.cfg_valid && cfg.cfg_ready;
    assign len_ok        = (cfg.cfg_len != '0) && (cfg.cfg_len <= LEN_W'(MAX_LEN));
    assign start_go      = start && !abort && (state_q != ST_ARMED);
    assign sample_en     = (state_q == ST_ARMED) && x_valid && !abort;
    assign clear         = abort || start_go;
    assign cnt_inc       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    seq_match_core #(.MAX_LEN(MAX_LEN)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear),
        .sample_i  (sample_en),
        .x_i       (x),
        .pattern_i (pat_q),
        .len_i     (len_q),
        .overlap_i (ovl_q),
        .hit_o     (hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_go) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort) state_d = ST_IDLE;
                else if (hit && (tgt_q != '0) && (cnt_inc == tgt_q)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (abort) state_d = ST_IDLE;
                else if (start) state_d = ST_ARMED;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= MAX_LEN'(DEF_PATTERN);
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= 1'b1;
            tgt_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= hit;
            err_q   <= cfg_fire && !len_ok;
            if (cfg_fire && len_ok) begin
                pat_q <= cfg.cfg_pattern;
                len_q <= cfg.cfg_len;
                ovl_q <= cfg.cfg_overlap;
                tgt_q <= cfg.cfg_target;
            end
            if (start_go) cnt_q <= '0;
            else if (hit) cnt_q <= cnt_inc;
        end
    end

    assign cfg.cfg_err  = err_q;
    assign match        = match_q;
    assign match_cnt    = cnt_q;
    assign busy         = (state_q == ST_ARMED);
    assign done         = (state_q == ST_DONE);
    assign dbg_state_o  = state_q;

endmodule
